// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: walks the fetch PC, issues line reads,
// buffers each 128-bit line and serves words to decode via valid/ready.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_LATENCY = 1
) (
  input  logic         CLk,
  input  logic         Rst_n,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  input  logic         inst_ready,
  output logic         inst_valid,
  output logic [31:0]  inst,
  output logic [31:0]  inst_pc,
  output logic [31:0]  mem_address,
  input  logic [127:0] mem_instruction,
  output logic [15:0]  fetch_count
);

  localparam logic [1:0]  REQ   = 2'd0;
  localparam logic [1:0]  WAIT  = 2'd1;
  localparam logic [1:0]  SERVE = 2'd2;
  localparam logic [31:0] PC_RST = RESET_PC & ~32'd3;
  localparam logic [2:0]  LAT   = 3'(MEM_LATENCY);

  logic [1:0]   state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [127:0] line_q, line_d;
  logic [2:0]   lat_q, lat_d;
  logic [15:0]  fcnt_q, fcnt_d;
  logic         serve;

  assign serve       = (state_q == SERVE);
  assign inst_valid  = serve;
  assign inst_pc     = pc_q;
  assign mem_address = {4'b0, pc_q[31:4]};
  assign fetch_count = fcnt_q;
  assign inst        = serve ? line_q[{pc_q[3:2], 5'd0} +: 32] : 32'd0;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    line_d  = line_q;
    lat_d   = lat_q;
    fcnt_d  = fcnt_q;
    // a redirect drops any in-flight read before it can be captured
    if (redirect_valid) begin
      pc_d    = redirect_pc & ~32'd3;
      state_d = REQ;
      lat_d   = 3'd0;
    end else begin
      unique case (1'b1)
        state_q == REQ: begin
          state_d = WAIT;
          lat_d   = LAT;
        end
        state_q == WAIT: begin
          lat_d = lat_q - 3'd1;
          if (lat_q == 3'd1) begin
            line_d  = mem_instruction;
            fcnt_d  = fcnt_q + 16'd1;
            state_d = SERVE;
          end
        end
        state_q == SERVE: begin
          if (inst_ready) begin
            pc_d = pc_q + 32'd4;
            if (pc_q[3:2] == 2'd3) state_d = REQ;
          end
        end
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge CLk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= REQ;
      pc_q    <= PC_RST;
      line_q  <= '0;
      lat_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      line_q  <= line_d;
      lat_q   <= lat_d;
      fcnt_q  <= fcnt_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed vector table, wrap/reset sequences
// and random redirect/backpressure against a cycles-to-valid model.
module tb_inst_fetch_ctrl;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        v;
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] adr;
    logic [15:0] fc;
  } vec_t;

  logic clk = 0;
  logic rst_n = 0;
  logic rv = 0;
  logic [31:0] rpc = 0;
  logic rdy = 0;

  logic iv0, iv1;
  logic [31:0] ins0, ins1, ipc0, ipc1, madr0, madr1;
  logic [127:0] mi0, mi1;
  logic [15:0] fc0, fc1;

  logic [31:0] h0 = 0;
  logic [31:0] h1 [3] = '{0, 0, 0};

  int errs = 0;
  int checks = 0;

  int          m_wait [2];
  logic [31:0] m_pc [2];
  logic [15:0] m_fc [2];
  int          m_lat [2] = '{1, 3};

  vec_t tab [27];

  always #5 clk = ~clk;

  inst_fetch_ctrl #(.RESET_PC(32'h0), .MEM_LATENCY(1)) u_dut (
    .CLk(clk), .Rst_n(rst_n),
    .redirect_valid(rv), .redirect_pc(rpc), .inst_ready(rdy),
    .inst_valid(iv0), .inst(ins0), .inst_pc(ipc0),
    .mem_address(madr0), .mem_instruction(mi0), .fetch_count(fc0)
  );

  inst_fetch_ctrl #(.RESET_PC(32'h0), .MEM_LATENCY(3)) u_dut3 (
    .CLk(clk), .Rst_n(rst_n),
    .redirect_valid(rv), .redirect_pc(rpc), .inst_ready(rdy),
    .inst_valid(iv1), .inst(ins1), .inst_pc(ipc1),
    .mem_address(madr1), .mem_instruction(mi1), .fetch_count(fc1)
  );

  // line a holds words 4a..4a+3, so the word at byte pc is pc>>2
  function automatic logic [127:0] line(input logic [31:0] a);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[32*w +: 32] = a * 4 + 32'(w);
    return l;
  endfunction

  // memories return the line addressed LAT cycles earlier
  always @(posedge clk) begin
    h0    <= madr0;
    h1[0] <= madr1;
    h1[1] <= h1[0];
    h1[2] <= h1[1];
  end
  assign mi0 = line(h0);
  assign mi1 = line(h1[2]);

  function automatic vec_t mk(
    input logic r, input logic [31:0] p, input logic y,
    input logic v, input logic [31:0] i, input logic [31:0] c,
    input logic [31:0] a, input logic [15:0] f);
    vec_t t;
    t.rv = r; t.rpc = p; t.rdy = y; t.v = v;
    t.ins = i; t.pc = c; t.adr = a; t.fc = f;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_wait[d] = m_lat[d] + 1;
      m_pc[d]   = 32'h0;
      m_fc[d]   = 16'h0;
    end
  endtask

  task automatic model_upd(input int d, input logic r,
                           input logic [31:0] p, input logic y);
    if (r) begin
      m_pc[d]   = p & ~32'd3;
      m_wait[d] = m_lat[d] + 1;
    end else if (m_wait[d] > 0) begin
      if (m_wait[d] == 1) m_fc[d] = m_fc[d] + 16'd1;
      m_wait[d]--;
    end else if (y) begin
      if (m_pc[d][3:2] == 2'd3) m_wait[d] = m_lat[d] + 1;
      m_pc[d] = m_pc[d] + 32'd4;
    end
  endtask

  task automatic chk_model(input int d);
    logic        v;
    logic [31:0] i, c, a;
    logic [15:0] f;
    logic        ev;
    if (d == 0) begin v = iv0; i = ins0; c = ipc0; a = madr0; f = fc0; end
    else begin v = iv1; i = ins1; c = ipc1; a = madr1; f = fc1; end
    ev = (m_wait[d] == 0);
    chk($sformatf("m%0d_valid", d), 32'(v), 32'(ev));
    chk($sformatf("m%0d_inst", d), i, ev ? m_pc[d] >> 2 : 32'h0);
    chk($sformatf("m%0d_pc", d), c, m_pc[d]);
    chk($sformatf("m%0d_addr", d), a, m_pc[d] >> 4);
    chk($sformatf("m%0d_fc", d), 32'(f), 32'(m_fc[d]));
  endtask

  task automatic step(input logic r, input logic [31:0] p,
                      input logic y, input bit use_tab, input vec_t t);
    rv = r; rpc = p; rdy = y;
    @(negedge clk);
    chk_model(0);
    chk_model(1);
    if (use_tab) begin
      chk("tab_valid", 32'(iv0), 32'(t.v));
      chk("tab_inst", ins0, t.ins);
      chk("tab_pc", ipc0, t.pc);
      chk("tab_addr", madr0, t.adr);
      chk("tab_fc", 32'(fc0), 32'(t.fc));
    end
    @(posedge clk);
    model_upd(0, r, p, y);
    model_upd(1, r, p, y);
    #1;
  endtask

  task automatic run_tab(input int lo, input int hi);
    for (int k = lo; k <= hi; k++)
      step(tab[k].rv, tab[k].rpc, tab[k].rdy, 1'b1, tab[k]);
  endtask

  task automatic bubbles(input string nm, input int exp);
    int n = 0;
    while (!iv1 && n < 20) begin
      step(0, 0, 1, 1'b0, tab[0]);
      n++;
    end
    chk(nm, 32'(n), 32'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    tab[0]  = mk(0, 0, 1, 0, 0, 32'h00, 0, 0);
    tab[1]  = mk(0, 0, 1, 0, 0, 32'h00, 0, 0);
    tab[2]  = mk(0, 0, 1, 1, 0, 32'h00, 0, 1);
    for (int k = 3; k <= 7; k++)
      tab[k] = mk(0, 0, 0, 1, 1, 32'h04, 0, 1);
    tab[8]  = mk(0, 0, 1, 1, 1, 32'h04, 0, 1);
    tab[9]  = mk(0, 0, 1, 1, 2, 32'h08, 0, 1);
    tab[10] = mk(0, 0, 1, 1, 3, 32'h0C, 0, 1);
    tab[11] = mk(0, 0, 1, 0, 0, 32'h10, 1, 1);
    tab[12] = mk(0, 0, 1, 0, 0, 32'h10, 1, 1);
    tab[13] = mk(0, 0, 1, 1, 4, 32'h10, 1, 2);
    tab[14] = mk(0, 0, 1, 1, 5, 32'h14, 1, 2);
    tab[15] = mk(0, 0, 1, 1, 6, 32'h18, 1, 2);
    tab[16] = mk(0, 0, 1, 1, 7, 32'h1C, 1, 2);
    tab[17] = mk(0, 0, 1, 0, 0, 32'h20, 2, 2);
    tab[18] = mk(1, 32'h26, 1, 0, 0, 32'h20, 2, 2);
    tab[19] = mk(0, 0, 1, 0, 0, 32'h24, 2, 2);
    tab[20] = mk(0, 0, 1, 0, 0, 32'h24, 2, 2);
    tab[21] = mk(0, 0, 1, 1, 9, 32'h24, 2, 3);
    tab[22] = mk(1, 32'h40, 1, 1, 10, 32'h28, 2, 3);
    tab[23] = mk(0, 0, 1, 0, 0, 32'h40, 4, 3);
    tab[24] = mk(0, 0, 1, 0, 0, 32'h40, 4, 3);
    tab[25] = mk(0, 0, 1, 1, 16, 32'h40, 4, 4);
    tab[26] = mk(0, 0, 0, 1, 17, 32'h44, 4, 4);

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(iv0), 32'h0);
    chk("rst_inst", ins0, 32'h0);
    chk("rst_pc", ipc0, 32'h0);
    chk("rst_fc", 32'(fc0), 32'h0);
    rst_n = 1;

    run_tab(0, 26);

    #2 rst_n = 0;
    #1;
    chk("arst_valid", 32'(iv0), 32'h0);
    chk("arst_inst", ins0, 32'h0);
    chk("arst_fc", 32'(fc0), 32'h0);
    chk("arst_pc", ipc0, 32'h0);
    chk("arst3_fc", 32'(fc1), 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    run_tab(0, 14);

    step(1, 32'hFFFF_FFF8, 1, 1'b0, tab[0]);
    bubbles("wrap_lat", 4);
    chk("wrap_pc0", ipc1, 32'hFFFF_FFF8);
    chk("wrap_ins0", ins1, 32'h3FFF_FFFE);
    step(0, 0, 1, 1'b0, tab[0]);
    chk("wrap_pc1", ipc1, 32'hFFFF_FFFC);
    step(0, 0, 1, 1'b0, tab[0]);
    chk("wrap_pc2", ipc1, 32'h0);
    chk("wrap_addr", madr1, 32'h0);
    bubbles("wrap_bub", 4);
    chk("wrap_ins2", ins1, 32'h0);

    for (int k = 0; k < 2000; k++) begin
      logic        r;
      logic [31:0] p;
      r = ($urandom % 12) == 0;
      p = ($urandom % 4 == 0) ? (32'hFFFF_FFC0 | ($urandom % 64))
                              : $urandom;
      step(r, p, ($urandom % 4) != 0, 1'b0, tab[0]);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
